multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM with memory wait timeout (optional ILLEGAL_TRAP_EN)
module multicycle_control #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       alu_src,
    output logic       bus_err,
    output logic [1:0] imm_select,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
`ifdef ILLEGAL_TRAP_EN
        WRITEBACK = 3'd4,
        TRAP      = 3'd5
`else
        WRITEBACK = 3'd4
`endif
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;

    logic is_r;
    logic is_i;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_legal;
    logic in_wait_state;
    logic timeout;
    logic branch_taken;
    logic [1:0] imm_dec;

    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_legal  = is_r | is_i | is_load | is_store | is_branch;

    // Only FETCH and MEM wait on memory; a late mem_ready still beats the timeout.
    assign in_wait_state = (state == FETCH) || (state == MEM);
    assign timeout       = in_wait_state && !mem_ready && (wait_cnt == TIMEOUT_CNT);

    // BEQ and BNE are the only taken branch kinds.
    assign branch_taken = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

    // Immediate format select from opcode; R-type and unknown opcodes use 00.
    always_comb begin
        imm_dec = 2'b00;
        if (is_store)
            imm_dec = 2'b01;
        else if (is_branch)
            imm_dec = 2'b10;
    end

    assign state_o = state;

    // State register; reset forces FETCH without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= FETCH;
        else
            state <= state_next;
    end

    // Wait counter: cleared on any state entry or timeout, counts idle memory cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= 8'd0;
        else if (timeout || (state_next != state))
            wait_cnt <= 8'd0;
        else if (in_wait_state && !mem_ready)
            wait_cnt <= wait_cnt + 8'd1;
    end

    // Next-state and output decode; pulses are masked while reset is held.
    always_comb begin
        state_next = state;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        bus_err    = 1'b0;
        imm_select = 2'b00;

        case (state)
            FETCH: begin
                if (timeout) begin
                    bus_err    = 1'b1;
                    state_next = FETCH;
                end else begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        state_next = DECODE;
                    end
                end
            end

            DECODE: begin
                imm_select = imm_dec;
                if (is_legal)
                    state_next = EXECUTE;
                else
`ifdef ILLEGAL_TRAP_EN
                    state_next = TRAP;
`else
                    state_next = FETCH;
`endif
            end

            EXECUTE: begin
                imm_select = imm_dec;
                alu_src    = !(is_r || is_branch);
                if (is_branch) begin
                    pc_write   = branch_taken;
                    state_next = FETCH;
                end else if (is_load || is_store)
                    state_next = MEM;
                else if (is_r || is_i)
                    state_next = WRITEBACK;
                else
                    state_next = FETCH;
            end

            MEM: begin
                if (timeout) begin
                    bus_err    = 1'b1;
                    state_next = FETCH;
                end else begin
                    mem_read  = is_load;
                    mem_write = is_store;
                    if (mem_ready)
                        state_next = is_load ? WRITEBACK : FETCH;
                end
            end

            WRITEBACK: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end

`ifdef ILLEGAL_TRAP_EN
            TRAP: begin
                bus_err    = 1'b1;
                state_next = TRAP;
            end
`endif

            default: state_next = FETCH;
        endcase

        if (!rst_n) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            bus_err   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized instruction-level check of multicycle_control (MEM_TIMEOUT=4)
module tb_multicycle_control;

    localparam int TO = 4;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_L   = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [2:0] S_F = 3'd0;
    localparam logic [2:0] S_D = 3'd1;
    localparam logic [2:0] S_E = 3'd2;
    localparam logic [2:0] S_M = 3'd3;
    localparam logic [2:0] S_W = 3'd4;
    localparam logic [2:0] S_T = 3'd5;

    // {pc_write, ir_write, reg_write, mem_read, mem_write, alu_src, bus_err, imm_select}
    localparam logic [8:0] O_FETCH = 9'b000100000;
    localparam logic [8:0] O_FDONE = 9'b110100000;
    localparam logic [8:0] O_BERR  = 9'b000000100;
    localparam logic [8:0] O_RD    = 9'b000100000;
    localparam logic [8:0] O_WR    = 9'b000010000;
    localparam logic [8:0] O_WB    = 9'b001000000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, reg_write, mem_read, mem_write, alu_src, bus_err;
    logic [1:0] imm_select;
    logic [2:0] state_o;
    logic [8:0] outs;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_idx  = 0;

    typedef struct {
        logic [2:0] st;
        logic [8:0] o;
        logic       mr;
        logic       z;
        logic [6:0] op;
        logic [2:0] f3;
    } cyc_t;

    cyc_t q[$];

    multicycle_control #(.MEM_TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .alu_src    (alu_src),
        .bus_err    (bus_err),
        .imm_select (imm_select),
        .state_o    (state_o)
    );

    assign outs = {pc_write, ir_write, reg_write, mem_read, mem_write, alu_src, bus_err, imm_select};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        if (op == OP_S) return 2'b01;
        if (op == OP_B) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_L) || (op == OP_S) || (op == OP_B);
    endfunction

    task automatic push(input logic [2:0] st, input logic [8:0] o, input logic mr, input logic z,
                        input logic [6:0] op, input logic [2:0] f3);
        cyc_t c;
        c.st = st; c.o = o; c.mr = mr; c.z = z; c.op = op; c.f3 = f3;
        q.push_back(c);
    endtask

    // One instruction as a cycle list: fd/md are idle memory cycles before mem_ready in FETCH/MEM.
    task automatic add_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input int fd, input int md);
        logic [1:0] imm;
        logic       taken;
        logic [8:0] act;
        imm = imm_of(op);
        for (int k = 0; k <= fd; k++) begin
            if (k == fd)                push(S_F, O_FDONE, 1'b1, rb(), op, f3);
            else if (k % (TO + 1) == TO) push(S_F, O_BERR, 1'b0, rb(), op, f3);
            else                        push(S_F, O_FETCH, 1'b0, rb(), op, f3);
        end
        push(S_D, {7'b0, imm}, rb(), rb(), op, f3);
        if (!legal(op)) begin
`ifdef ILLEGAL_TRAP_EN
            for (int k = 0; k < 4; k++) push(S_T, O_BERR, rb(), rb(), op, f3);
`endif
            return;
        end
        taken = (op == OP_B) && (((f3 == 3'b000) && z) || ((f3 == 3'b001) && !z));
        push(S_E, {taken, 4'b0, !((op == OP_R) || (op == OP_B)), 1'b0, imm}, rb(), z, op, f3);
        if ((op == OP_R) || (op == OP_I)) begin
            push(S_W, O_WB, rb(), rb(), op, f3);
            return;
        end
        if (op == OP_B) return;
        act = (op == OP_L) ? O_RD : O_WR;
        for (int k = 0; k <= md; k++) begin
            if (k == md) push(S_M, act, 1'b1, rb(), op, f3);
            else if (k % (TO + 1) == TO) begin
                push(S_M, O_BERR, 1'b0, rb(), op, f3);
                return;
            end else push(S_M, act, 1'b0, rb(), op, f3);
        end
        if (op == OP_L) push(S_W, O_WB, rb(), rb(), op, f3);
    endtask

    // Starts and ends on a falling edge: drive, settle, compare, advance.
    task automatic run_n(input int n);
        cyc_t c;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            c = q.pop_front();
            opcode = c.op; funct3 = c.f3; zero = c.z; mem_ready = c.mr;
            #1;
            check($sformatf("state@%0d", cyc_idx), 32'(state_o), 32'(c.st));
            check($sformatf("outs@%0d", cyc_idx), 32'(outs), 32'(c.o));
            check($sformatf("rdwr_excl@%0d", cyc_idx), 32'(mem_read & mem_write), 32'd0);
            cyc_idx++;
            @(negedge clk);
        end
    endtask

    task automatic run_all();
        run_n(q.size());
    endtask

    function automatic logic [6:0] rand_op();
        logic [6:0] ops [7];
        ops = '{OP_R, OP_I, OP_L, OP_S, OP_B, OP_BAD, OP_LUI};
`ifdef ILLEGAL_TRAP_EN
        return ops[$urandom_range(0, 4)];
`else
        return ops[$urandom_range(0, 6)];
`endif
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        mem_ready = 1'b1;
        opcode = OP_S;
        repeat (2) @(negedge clk);
        #1;
        check("rst_state", 32'(state_o), 32'(S_F));
        check("rst_outs", 32'(outs), 32'(O_FETCH));
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;

        add_instr(OP_R, 3'b000, 1'b0, 1, 0);
        add_instr(OP_L, 3'b010, 1'b0, 0, 3);
        add_instr(OP_S, 3'b010, 1'b0, 2, 1);
        add_instr(OP_B, 3'b000, 1'b1, 0, 0);
        add_instr(OP_B, 3'b001, 1'b1, 0, 0);
        add_instr(OP_B, 3'b001, 1'b0, 0, 0);
        add_instr(OP_B, 3'b100, 1'b1, 0, 0);
        add_instr(OP_I, 3'b000, 1'b0, 4, 0);
        add_instr(OP_R, 3'b000, 1'b0, 5, 0);
        add_instr(OP_S, 3'b000, 1'b0, 0, 6);
        add_instr(OP_L, 3'b000, 1'b0, 0, 4);
        run_all();

        for (int n = 0; n < 40; n++) begin
            add_instr(rand_op(), 3'($urandom_range(0, 7)), rb(),
                      $urandom_range(0, 6), $urandom_range(0, 6));
            run_all();
        end

        add_instr(OP_S, 3'b010, 1'b0, 0, 3);
        run_n(4);
        opcode = OP_S;
        mem_ready = 1'b1;
        #1;
        check("pre_rst_state", 32'(state_o), 32'(S_M));
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(state_o), 32'(S_F));
        check("mid_rst_outs", 32'(outs), 32'(O_FETCH));
        q.delete();
        @(negedge clk);
        #1;
        check("hold_rst_outs", 32'(outs), 32'(O_FETCH));
        @(negedge clk);
        rst_n = 1'b1;
        add_instr(OP_R, 3'b000, 1'b0, 4, 0);
        run_all();

        add_instr(OP_BAD, 3'b000, 1'b0, 0, 0);
`ifndef ILLEGAL_TRAP_EN
        add_instr(OP_I, 3'b000, 1'b0, 1, 0);
`endif
        run_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
